// File: rtl/rtc_arb_pkg.sv
// Shared definitions for the RTC access arbiter: FSM encoding, requester
// indices, parameter defaults and a small index-to-one-hot helper.
package rtc_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] REQ_SWEEP = 2'd0;
  localparam logic [1:0] REQ_EDIT  = 2'd1;
  localparam logic [1:0] REQ_ALARM = 2'd2;

  localparam int LOCK_MAX_DEF = 16;
  localparam int TIMEOUT_DEF  = 255;

  function automatic logic [2:0] idx2onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rtc_access_arbiter_if.sv
// Requester and RTC-engine signal bundle for rtc_access_arbiter.
// slave  : the arbiter's view.
// master : the environment's view (requesters plus engine response).
interface rtc_access_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  // Requester side
  logic [2:0]        Req;
  logic [2:0]        Lock;
  logic [2:0]        Wr;
  logic [ADDR_W-1:0] Addr0, Addr1, Addr2;
  logic [DATA_W-1:0] Wdata0, Wdata1, Wdata2;
  logic [2:0]        Ack;
  logic              Err;
  logic [DATA_W-1:0] Rdata;
  logic              Busy;
  // Engine side
  logic              Acceso;
  logic              RtcWr;
  logic [ADDR_W-1:0] Dir;
  logic [DATA_W-1:0] Dout;
  logic              FRW;
  logic [DATA_W-1:0] Din;

  modport slave (
    input  Req, Lock, Wr, Addr0, Addr1, Addr2, Wdata0, Wdata1, Wdata2, FRW, Din,
    output Ack, Err, Rdata, Busy, Acceso, RtcWr, Dir, Dout
  );

  modport master (
    output Req, Lock, Wr, Addr0, Addr1, Addr2, Wdata0, Wdata1, Wdata2, FRW, Din,
    input  Ack, Err, Rdata, Busy, Acceso, RtcWr, Dir, Dout
  );
endinterface

// File: rtl/rtc_arb_pick.sv
// Combinational winner select: the previous owner keeps the engine while it
// holds Req+Lock and its burst budget is not spent, otherwise fixed priority
// alarm > edit > sweep.
module rtc_arb_pick
  import rtc_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [2:0] lock_i,
  input  logic [1:0] owner_i,
  input  logic       lock_ok_i,
  output logic [2:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       hold_o
);

  // Lock hold first, then fixed priority.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    idx_o  = REQ_SWEEP;
    hold_o = 1'b0;
    if (lock_ok_i && req_i[owner_i] && lock_i[owner_i]) begin
      idx_o  = owner_i;
      hold_o = 1'b1;
    end else if (req_i[REQ_ALARM]) begin
      idx_o = REQ_ALARM;
    end else if (req_i[REQ_EDIT]) begin
      idx_o = REQ_EDIT;
    end
    gnt_o = (|req_i) ? idx2onehot(idx_o) : 3'b000;
  end

endmodule

// File: rtl/rtc_access_arbiter.sv
// Arbiter/sequencer sharing the single RTC read/write engine between the
// menu sweep, user edits and alarm acknowledge. One engine access per grant,
// registered Ack/Rdata back to the winner.
// Optional macro RTC_ARB_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles and
// report it on Err; when undefined WAIT waits for FRW forever and Err = 0.
module rtc_access_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = LOCK_MAX_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  rtc_access_arbiter_if.slave bus
);

  localparam int BC_W = $clog2(LOCK_MAX + 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q;
  logic [BC_W-1:0]   burst_cnt_q;
  logic              acceso_q, rtcwr_q, busy_q;
  logic [ADDR_W-1:0] dir_q;
  logic [DATA_W-1:0] dout_q, rdata_q;
  logic [2:0]        ack_q;

  logic [2:0]        pick_gnt;
  logic [1:0]        pick_idx;
  logic              pick_hold, lock_ok, to_hit;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // burst_cnt of 0 means no previous owner yet, so no lock hold is possible.
  assign lock_ok = (burst_cnt_q != '0) && (int'(burst_cnt_q) < LOCK_MAX);

  rtc_arb_pick u_pick (
    .req_i     (bus.Req),
    .lock_i    (bus.Lock),
    .owner_i   (owner_q),
    .lock_ok_i (lock_ok),
    .gnt_o     (pick_gnt),
    .idx_o     (pick_idx),
    .hold_o    (pick_hold)
  );

  // Route the winner's direction, address and write data.
  always_comb begin
    sel_wr    = bus.Wr[pick_idx];
    sel_addr  = bus.Addr0;
    sel_wdata = bus.Wdata0;
    case (pick_idx)
      REQ_EDIT:  begin sel_addr = bus.Addr1; sel_wdata = bus.Wdata1; end
      REQ_ALARM: begin sel_addr = bus.Addr2; sel_wdata = bus.Wdata2; end
      default:   ;
    endcase
  end

  // Next-state logic; FRW wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|pick_gnt) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.FRW || to_hit) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state, latched transaction, burst tracking and registered outputs.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_SWEEP;
      burst_cnt_q <= '0;
      acceso_q    <= 1'b0;
      rtcwr_q     <= 1'b0;
      busy_q      <= 1'b0;
      dir_q       <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= 3'b000;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != ST_IDLE);
      acceso_q <= 1'b0;
      ack_q    <= 3'b000;
      case (state_q)
        ST_IDLE: if (|pick_gnt) begin
          owner_q     <= pick_idx;
          burst_cnt_q <= pick_hold ? burst_cnt_q + 1'b1 : BC_W'(1);
          rtcwr_q     <= sel_wr;
          dir_q       <= sel_addr;
          dout_q      <= sel_wdata;
          acceso_q    <= 1'b1;
        end
        ST_WAIT: if (state_d == ST_DONE) begin
          ack_q <= idx2onehot(owner_q);
          if (bus.FRW && !rtcwr_q) rdata_q <= bus.Din;
        end
        default: ;
      endcase
    end
  end

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT));

  // Timeout counter: cleared at issue, counts cycles spent in WAIT.
  always_ff @(posedge CLK) begin
    if (RST)                    to_cnt_q <= '0;
    else if (state_q == ST_ISSUE) to_cnt_q <= '0;
    else if (state_q == ST_WAIT)  to_cnt_q <= to_cnt_q + 1'b1;
  end

  // Err accompanies Ack only when the wait expired without FRW.
  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= (state_q == ST_WAIT) && !bus.FRW && to_hit;
  end

  assign bus.Err = err_q;
`else
  assign to_hit  = 1'b0;
  assign bus.Err = 1'b0;
`endif

  assign bus.Ack    = ack_q;
  assign bus.Rdata  = rdata_q;
  assign bus.Busy   = busy_q;
  assign bus.Acceso = acceso_q;
  assign bus.RtcWr  = rtcwr_q;
  assign bus.Dir    = dir_q;
  assign bus.Dout   = dout_q;

endmodule
